// File: rtl/pipe_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: NOP encoding, register-field
// positions and PC arithmetic.
package pipe_pkg;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
    localparam int          RS_MSB        = 25;
    localparam int          RS_LSB        = 21;
    localparam int          RT_MSB        = 20;
    localparam int          RT_LSB        = 16;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = ~32'h3;

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction sitting in IF/ID may read. rt is compared for every format.
module hazard_detect (
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    output logic       hazard
);

    // $zero is never a real dependency, so a load targeting it cannot stall.
    assign hazard = EX_MemRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register: PC, instruction latch, load-use stall,
// taken-branch flush and saturating stall/flush counters.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      imem_rdata,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             MEM_BranchTaken,
    input  logic [31:0]      MEM_BranchTarget,
    output logic [31:0]      imem_addr,
    output logic [31:0]      ID_instr,
    output logic [31:0]      ID_pc4,
    output logic             ID_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      pc_plus4;
    logic             hazard;
    logic             flush;
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    hazard_detect u_hazard_detect (
        .EX_MemRead (EX_MemRead),
        .EX_rt      (EX_rt),
        .ID_rs      (instr_q[RS_MSB:RS_LSB]),
        .ID_rt      (instr_q[RT_MSB:RT_LSB]),
        .hazard     (hazard)
    );

    assign flush    = MEM_BranchTaken;
    assign pc_plus4 = pc_q + PC_INC;

    // Priority flush > stall > advance; a hazard coincident with a flush is moot
    // because the dependent instruction is being squashed anyway.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        cnt_inc = 2'b00;
        if (flush) begin
            pc_d       = MEM_BranchTarget & PC_ALIGN_MASK;
            instr_d    = NOP_WORD;
            pc4_d      = 32'h0;
            cnt_inc[1] = 1'b1;
        end else if (hazard) begin
            cnt_inc[0] = 1'b1;
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // Index 0 counts stall cycles, index 1 counts flushes; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (cnt_inc[gi] && (cnt_q[gi] != {CNT_W{1'b1}}))
                    cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q[gi] <= '0;
                else
                    cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    assign imem_addr   = pc_q;
    assign ID_instr    = instr_q;
    assign ID_pc4      = pc4_q;
    assign ID_bubble   = hazard | flush;
    assign stall_count = cnt_q[0];
    assign flush_count = cnt_q[1];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch sequencing, load-use stall, flush
// priority, PC wrap, counter saturation and asynchronous reset.
module tb_if_id_stage;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [31:0]      imem_rdata;
    logic             EX_MemRead;
    logic [4:0]       EX_rt;
    logic             MEM_BranchTaken;
    logic [31:0]      MEM_BranchTarget;
    logic [31:0]      imem_addr;
    logic [31:0]      ID_instr;
    logic [31:0]      ID_pc4;
    logic             ID_bubble;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage #(.RESET_PC(32'h100), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_rdata       (imem_rdata),
        .EX_MemRead       (EX_MemRead),
        .EX_rt            (EX_rt),
        .MEM_BranchTaken  (MEM_BranchTaken),
        .MEM_BranchTarget (MEM_BranchTarget),
        .imem_addr        (imem_addr),
        .ID_instr         (ID_instr),
        .ID_pc4           (ID_pc4),
        .ID_bubble        (ID_bubble),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_rdata = 32'h0; EX_MemRead = 1'b0; EX_rt = 5'd0;
        MEM_BranchTaken = 1'b0; MEM_BranchTarget = 32'h0;
        repeat (2) tick();
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h exp %h", imem_addr, 32'h100); end
        n_checks++; if (ID_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", ID_instr, 32'h0); end
        n_checks++; if (ID_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp %h", ID_pc4, 32'h0); end
        n_checks++; if (stall_count !== 16'h0 || flush_count !== 16'h0) begin n_fail++; $display("FAIL reset_counts got %h/%h exp 0/0", stall_count, flush_count); end
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got %b exp 0", ID_bubble); end
        rst_n = 1'b1;
        $display("txn reset: pc=%h instr=%h pc4=%h", imem_addr, ID_instr, ID_pc4);
    endtask

    task automatic test_fetch();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'h100 + 32'(4 * i);
            n_checks++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL fetch%0d_pc got %h exp %h", i, imem_addr, exp_pc); end
            n_checks++; if (ID_pc4 !== exp_pc) begin n_fail++; $display("FAIL fetch%0d_pc4 got %h exp %h", i, ID_pc4, exp_pc); end
            $display("txn fetch%0d: pc=%h pc4=%h", i, imem_addr, ID_pc4);
        end
    endtask

    task automatic test_load_use();
        imem_rdata = 32'h8CA6_0000;          // lw $6,0($5): rs=5
        tick();                              // PC 10C -> 110
        n_checks++; if (ID_instr !== 32'h8CA6_0000) begin n_fail++; $display("FAIL lu_load got %h exp %h", ID_instr, 32'h8CA6_0000); end
        imem_rdata = 32'h0000_0020;
        EX_MemRead = 1'b1; EX_rt = 5'd5;
        #1;
        n_checks++; if (ID_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b exp 1", ID_bubble); end
        tick();
        n_checks++; if (imem_addr !== 32'h110) begin n_fail++; $display("FAIL lu_pc_hold got %h exp %h", imem_addr, 32'h110); end
        n_checks++; if (ID_instr !== 32'h8CA6_0000) begin n_fail++; $display("FAIL lu_instr_hold got %h exp %h", ID_instr, 32'h8CA6_0000); end
        n_checks++; if (ID_pc4 !== 32'h110) begin n_fail++; $display("FAIL lu_pc4_hold got %h exp %h", ID_pc4, 32'h110); end
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_stall_count got %0d exp 1", stall_count); end
        EX_MemRead = 1'b0;
        tick();
        n_checks++; if (imem_addr !== 32'h114 || ID_instr !== 32'h0000_0020) begin n_fail++; $display("FAIL lu_resume got pc=%h instr=%h exp pc=114 instr=00000020", imem_addr, ID_instr); end
        $display("txn load_use: pc=%h instr=%h stalls=%0d", imem_addr, ID_instr, stall_count);
    endtask

    task automatic test_no_false_stall();
        imem_rdata = 32'h0000_1020;          // rs=0, rt=0
        tick();                              // PC 118
        imem_rdata = 32'h00E7_4020;          // rs=7, rt=7
        EX_MemRead = 1'b1; EX_rt = 5'd0;
        #1;
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL nfs_zero_bubble got %b exp 0", ID_bubble); end
        tick();
        n_checks++; if (imem_addr !== 32'h11C || stall_count !== 16'd1) begin n_fail++; $display("FAIL nfs_zero_adv got pc=%h stalls=%0d exp pc=11c stalls=1", imem_addr, stall_count); end
        EX_MemRead = 1'b0; EX_rt = 5'd7;
        #1;
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL nfs_noread_bubble got %b exp 0", ID_bubble); end
        tick();
        n_checks++; if (imem_addr !== 32'h120 || stall_count !== 16'd1) begin n_fail++; $display("FAIL nfs_noread_adv got pc=%h stalls=%0d exp pc=120 stalls=1", imem_addr, stall_count); end
        $display("txn no_false_stall: pc=%h stalls=%0d", imem_addr, stall_count);
    endtask

    task automatic test_flush_priority();
        EX_MemRead = 1'b1; EX_rt = 5'd7;     // ID holds rs=rt=7: hazard live
        MEM_BranchTaken = 1'b1; MEM_BranchTarget = 32'h0000_2002;
        #1;
        n_checks++; if (ID_bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble got %b exp 1", ID_bubble); end
        tick();
        n_checks++; if (imem_addr !== 32'h2000) begin n_fail++; $display("FAIL flush_pc got %h exp %h", imem_addr, 32'h2000); end
        n_checks++; if (ID_instr !== 32'h0 || ID_pc4 !== 32'h0) begin n_fail++; $display("FAIL flush_ifid got instr=%h pc4=%h exp 0/0", ID_instr, ID_pc4); end
        n_checks++; if (flush_count !== 16'd1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", flush_count); end
        n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL flush_stall_count got %0d exp 1", stall_count); end
        MEM_BranchTaken = 1'b0; EX_MemRead = 1'b0;
        $display("txn flush: pc=%h flushes=%0d stalls=%0d", imem_addr, flush_count, stall_count);
    endtask

    task automatic test_wrap_and_saturate();
        MEM_BranchTaken = 1'b1; MEM_BranchTarget = 32'hFFFF_FFFF;
        tick();
        MEM_BranchTaken = 1'b0;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC || flush_count !== 16'd2) begin n_fail++; $display("FAIL wrap_setup got pc=%h flushes=%0d exp fffffffc/2", imem_addr, flush_count); end
        imem_rdata = 32'h8CA6_0000;
        tick();
        n_checks++; if (imem_addr !== 32'h0 || ID_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got pc=%h pc4=%h exp 0/0", imem_addr, ID_pc4); end
        $display("txn wrap: pc=%h pc4=%h", imem_addr, ID_pc4);
        EX_MemRead = 1'b1; EX_rt = 5'd5;
        repeat (65533) tick();
        n_checks++; if (stall_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_below got %h exp %h", stall_count, 16'hFFFE); end
        tick();
        n_checks++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp %h", stall_count, 16'hFFFF); end
        repeat (7) tick();
        n_checks++; if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp %h", stall_count, 16'hFFFF); end
        n_checks++; if (imem_addr !== 32'h0 || ID_instr !== 32'h8CA6_0000) begin n_fail++; $display("FAIL sat_pc_hold got pc=%h instr=%h exp 0/8ca60000", imem_addr, ID_instr); end
        $display("txn saturate: stalls=%h pc=%h", stall_count, imem_addr);
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;                        // mid-stall, well before the next edge
        #1;
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL areset_pc got %h exp %h", imem_addr, 32'h100); end
        n_checks++; if (ID_instr !== 32'h0 || ID_pc4 !== 32'h0) begin n_fail++; $display("FAIL areset_ifid got instr=%h pc4=%h exp 0/0", ID_instr, ID_pc4); end
        n_checks++; if (stall_count !== 16'h0 || flush_count !== 16'h0) begin n_fail++; $display("FAIL areset_counts got %h/%h exp 0/0", stall_count, flush_count); end
        n_checks++; if (ID_bubble !== 1'b0) begin n_fail++; $display("FAIL areset_bubble got %b exp 0", ID_bubble); end
        $display("txn async_reset: pc=%h instr=%h stalls=%0d", imem_addr, ID_instr, stall_count);
        EX_MemRead = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_wrap_and_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
